// File: rtl/tof_fw_mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency firmware memory between
// NB_OF_SENSORS requesters, with bounded per-grant bursts.
module tof_fw_mem_arbiter #(
    parameter int unsigned NB_OF_SENSORS = 8,
    parameter int unsigned ADDR_W        = 17,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned MEM_LATENCY   = 1,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NB_OF_SENSORS-1:0]         req,
    input  logic [NB_OF_SENSORS*ADDR_W-1:0]  addr_in,
    output logic [NB_OF_SENSORS-1:0]         gnt,
    output logic [NB_OF_SENSORS-1:0]         rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic                             mem_en,
    input  logic [DATA_W-1:0]                mem_dout,
    output logic                             busy
);

    localparam int unsigned IDX_W   = (NB_OF_SENSORS > 1) ? $clog2(NB_OF_SENSORS) : 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned LAT_W   = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [IDX_W-1:0]     last_idx, last_idx_nxt;
    logic [BURST_W-1:0]   burst, burst_nxt, burst_inc;
    logic [LAT_W-1:0]     lat_cnt, lat_nxt;
    logic [NB_OF_SENSORS-1:0] gnt_nxt, rd_valid_nxt;
    logic [DATA_W-1:0]    rd_data_nxt;
    logic [ADDR_W-1:0]    mem_addr_nxt;
    logic                 mem_en_nxt, busy_nxt;
    logic [IDX_W-1:0]     rr_pick;
    logic [ADDR_W-1:0]    addr_arr [NB_OF_SENSORS];

    always_comb begin
        for (int i = 0; i < int'(NB_OF_SENSORS); i++) begin
            addr_arr[i] = addr_in[i*ADDR_W +: ADDR_W];
        end
    end

    // First requester at or after last_idx+1, wrapping around.
    always_comb begin
        int unsigned cand;
        logic        found;
        rr_pick = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NB_OF_SENSORS; k++) begin
            cand = 32'(last_idx) + 1 + k;
            if (cand >= NB_OF_SENSORS) begin
                cand = cand - NB_OF_SENSORS;
            end
            if (!found && req[IDX_W'(cand)]) begin
                rr_pick = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so that mem_en/mem_addr are
    // on the bus during ISSUE and rd_valid during DONE; the address is therefore
    // taken on the edge entering ISSUE.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        last_idx_nxt = last_idx;
        burst_nxt    = burst;
        lat_nxt      = lat_cnt;
        gnt_nxt      = gnt;
        rd_valid_nxt = '0;
        rd_data_nxt  = rd_data;
        mem_addr_nxt = mem_addr;
        mem_en_nxt   = 1'b0;
        burst_inc    = burst + BURST_W'(1);

        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt      = rr_pick;
                    gnt_nxt      = NB_OF_SENSORS'(1) << rr_pick;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = addr_arr[rr_pick];
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                lat_nxt   = LAT_W'(MEM_LATENCY);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAT_W'(1)) begin
                    rd_data_nxt  = mem_dout;
                    rd_valid_nxt = gnt;
                    state_nxt    = DONE;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            DONE: begin
                if (req[idx] && (burst_inc < BURST_W'(MAX_BURST))) begin
                    burst_nxt    = burst_inc;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = addr_arr[idx];
                    state_nxt    = ISSUE;
                end else begin
                    gnt_nxt      = '0;
                    last_idx_nxt = idx;
                    burst_nxt    = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            last_idx <= IDX_W'(NB_OF_SENSORS - 1);
            burst    <= '0;
            lat_cnt  <= '0;
            gnt      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            last_idx <= last_idx_nxt;
            burst    <= burst_nxt;
            lat_cnt  <= lat_nxt;
            gnt      <= gnt_nxt;
            rd_valid <= rd_valid_nxt;
            rd_data  <= rd_data_nxt;
            mem_addr <= mem_addr_nxt;
            mem_en   <= mem_en_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_tof_fw_mem_arbiter.sv
// Directed bench: two arbiter instances (latency 1 / burst 4, latency 3 / burst 16)
// each in front of a behavioural firmware memory.
module tb_tof_fw_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req1, gnt1, rd_valid1;
    logic [135:0] addr1;
    logic [15:0] rd_data1, mdout1;
    logic [16:0] mem_addr1;
    logic        mem_en1, busy1;

    logic [7:0]  req3, gnt3, rd_valid3;
    logic [135:0] addr3;
    logic [15:0] rd_data3, p1, p2, p3;
    logic [16:0] mem_addr3;
    logic        mem_en3, busy3;

    int total;
    int bad;

    tof_fw_mem_arbiter #(.MEM_LATENCY(1), .MAX_BURST(4)) u_dut1 (
        .clk(clk), .reset(rst_n), .req(req1), .addr_in(addr1), .gnt(gnt1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .mem_addr(mem_addr1),
        .mem_en(mem_en1), .mem_dout(mdout1), .busy(busy1)
    );

    tof_fw_mem_arbiter #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .req(req3), .addr_in(addr3), .gnt(gnt3),
        .rd_valid(rd_valid3), .rd_data(rd_data3), .mem_addr(mem_addr3),
        .mem_en(mem_en3), .mem_dout(p3), .busy(busy3)
    );

    function automatic logic [15:0] mem_word(input logic [16:0] a);
        if (a == 17'h00010) return 16'hBEEF;
        return a[15:0] * 16'd3 + 16'h1234;
    endfunction

    always_ff @(posedge clk) begin
        if (mem_en1) mdout1 <= mem_word(mem_addr1);
    end

    always_ff @(posedge clk) begin
        if (mem_en3) p1 <= mem_word(mem_addr3);
        p2 <= p1;
        p3 <= p2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_addr1(input int i, input logic [16:0] a);
        addr1[i*17 +: 17] = a;
    endtask

    initial begin
        logic [7:0]  oh;
        logic [16:0] a;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req1  = '0;
        req3  = '0;
        addr1 = '0;
        addr3 = '0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_gnt", 32'(gnt1), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid1), 32'h0);
        chk("rst_rd_data", 32'(rd_data1), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr1), 32'h0);
        chk("rst_mem_en", 32'(mem_en1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_busy3", 32'(busy3), 32'h0);
        rst_n = 1'b1;

        // Single read, latency 1
        set_addr1(2, 17'h00010);
        req1 = 8'h04;
        chk("t1_c0_gnt", 32'(gnt1), 32'h0);
        tick();
        chk("t1_c1_gnt", 32'(gnt1), 32'h04);
        chk("t1_c1_mem_en", 32'(mem_en1), 32'h1);
        chk("t1_c1_mem_addr", 32'(mem_addr1), 32'h10);
        chk("t1_c1_busy", 32'(busy1), 32'h1);
        tick();
        chk("t1_c2_mem_en", 32'(mem_en1), 32'h0);
        chk("t1_c2_rd_valid", 32'(rd_valid1), 32'h0);
        tick();
        chk("t1_c3_rd_valid", 32'(rd_valid1), 32'h04);
        chk("t1_c3_rd_data", 32'(rd_data1), 32'hBEEF);
        req1 = 8'h00;
        tick();
        chk("t1_c4_gnt", 32'(gnt1), 32'h0);
        chk("t1_c4_busy", 32'(busy1), 32'h0);
        chk("t1_c4_rd_data_hold", 32'(rd_data1), 32'hBEEF);
        chk("t1_c4_mem_addr_hold", 32'(mem_addr1), 32'h10);

        // Round-robin over all eight requesters
        do_reset();
        for (int i = 0; i < 8; i++) set_addr1(i, 17'(i * 256));
        req1 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            tick();
            chk("t2_gnt", 32'(gnt1), 32'(oh));
            chk("t2_mem_addr", 32'(mem_addr1), 32'(i * 256));
            tick();
            tick();
            chk("t2_rd_valid", 32'(rd_valid1), 32'(oh));
            chk("t2_rd_data", 32'(rd_data1), 32'(mem_word(17'(i * 256))));
            req1[i] = 1'b0;
            tick();
            chk("t2_idle_gap_gnt", 32'(gnt1), 32'h0);
        end

        // Burst cap of 4 with a competing requester
        do_reset();
        a = 17'h00500;
        set_addr1(5, a);
        set_addr1(6, 17'h00600);
        req1 = 8'h60;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("t3_gnt", 32'(gnt1), 32'h20);
            chk("t3_rd_valid", 32'(rd_valid1), (c % 3 == 0) ? 32'h20 : 32'h0);
            if (c % 3 == 1) chk("t3_mem_addr", 32'(mem_addr1), 32'(a));
            if (c % 3 == 0) begin
                chk("t3_rd_data", 32'(rd_data1), 32'(mem_word(a)));
                a = a + 17'd1;
                set_addr1(5, a);
            end
        end
        tick();
        chk("t3_release_gnt", 32'(gnt1), 32'h0);
        chk("t3_release_rd_valid", 32'(rd_valid1), 32'h0);
        tick();
        chk("t3_next_gnt", 32'(gnt1), 32'h40);
        chk("t3_next_mem_addr", 32'(mem_addr1), 32'h600);
        req1 = 8'h00;

        // Early drop of the granted request during WAIT
        do_reset();
        set_addr1(1, 17'h00033);
        req1 = 8'h02;
        tick();
        chk("t4_c1_gnt", 32'(gnt1), 32'h02);
        chk("t4_c1_mem_en", 32'(mem_en1), 32'h1);
        tick();
        req1 = 8'h00;
        tick();
        chk("t4_c3_rd_valid", 32'(rd_valid1), 32'h02);
        chk("t4_c3_rd_data", 32'(rd_data1), 32'(mem_word(17'h00033)));
        tick();
        chk("t4_c4_gnt", 32'(gnt1), 32'h0);
        chk("t4_c4_mem_en", 32'(mem_en1), 32'h0);
        chk("t4_c4_busy", 32'(busy1), 32'h0);
        tick();
        chk("t4_c5_mem_en", 32'(mem_en1), 32'h0);
        chk("t4_c5_rd_valid", 32'(rd_valid1), 32'h0);

        // Reset during WAIT aborts the read; arbitration restarts at requester 0
        set_addr1(0, 17'h00040);
        set_addr1(7, 17'h00070);
        req1 = 8'h81;
        tick();
        chk("t5_pre_gnt", 32'(gnt1), 32'h80);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_abort_gnt", 32'(gnt1), 32'h0);
        chk("t5_abort_mem_en", 32'(mem_en1), 32'h0);
        chk("t5_abort_busy", 32'(busy1), 32'h0);
        chk("t5_abort_rd_data", 32'(rd_data1), 32'h0);
        chk("t5_abort_mem_addr", 32'(mem_addr1), 32'h0);
        chk("t5_abort_rd_valid", 32'(rd_valid1), 32'h0);
        tick();
        chk("t5_held_rd_valid", 32'(rd_valid1), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t5_restart_gnt", 32'(gnt1), 32'h01);
        chk("t5_restart_mem_addr", 32'(mem_addr1), 32'h40);
        tick();
        chk("t5_c2_rd_valid", 32'(rd_valid1), 32'h0);
        tick();
        chk("t5_c3_rd_valid", 32'(rd_valid1), 32'h01);
        chk("t5_c3_rd_data", 32'(rd_data1), 32'(mem_word(17'h00040)));
        req1 = 8'h00;
        tick();

        // Latency 3 instance, single read
        addr3[3*17 +: 17] = 17'h00077;
        req3 = 8'h08;
        tick();
        chk("t6_c1_gnt", 32'(gnt3), 32'h08);
        chk("t6_c1_mem_en", 32'(mem_en3), 32'h1);
        chk("t6_c1_mem_addr", 32'(mem_addr3), 32'h77);
        tick();
        tick();
        tick();
        chk("t6_c4_rd_valid", 32'(rd_valid3), 32'h0);
        chk("t6_c4_busy", 32'(busy3), 32'h1);
        tick();
        chk("t6_c5_rd_valid", 32'(rd_valid3), 32'h08);
        chk("t6_c5_rd_data", 32'(rd_data3), 32'(mem_word(17'h00077)));
        req3 = 8'h00;
        tick();
        chk("t6_c6_gnt", 32'(gnt3), 32'h0);
        chk("t6_c6_busy", 32'(busy3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
